// File: rtl/dec8b10b_link_sync.sv
// Link synchronisation and K28.5 word-alignment controller sitting beside the 8b10b decoder.
// Hunts for comma alignment via bitslip, runs a simplified clause-36 sync FSM, and counts slips/losses.
module dec8b10b_link_sync #(
    parameter int pSlipTimeout = 64,
    parameter int pSlipSettle  = 4,
    parameter int pCommaCount  = 3,
    parameter int pMaxBad      = 4,
    parameter int pGoodRun     = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Valid,
    output logic        o_DecEnable,
    output logic        o_DecSoftReset,
    input  logic [7:0]  i8_Dout,
    input  logic        i_Kout,
    input  logic        i_DErr,
    input  logic        i_DpErr,
    output logic        o_Bitslip,
    output logic        o_Synced,
    output logic [1:0]  o2_State,
    output logic [3:0]  o4_SlipCnt,
    output logic [15:0] o16_LossCnt
);

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_SLIP = 2'd1,
        ST_CD   = 2'd2,
        ST_SYNC = 2'd3
    } state_t;

    localparam logic [7:0] WORD_LAST   = 8'(pSlipTimeout - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(pSlipSettle - 1);
    localparam logic [3:0] COMMA_NEED  = 4'(pCommaCount);
    localparam logic [3:0] BAD_LAST    = 4'(pMaxBad - 1);
    localparam logic [7:0] GOOD_LAST   = 8'(pGoodRun - 1);

    state_t      state_reg, state_next;
    logic [7:0]  word_cnt_reg, word_cnt_next;
    logic [3:0]  settle_cnt_reg, settle_cnt_next;
    logic [3:0]  comma_cnt_reg, comma_cnt_next;
    logic [3:0]  bad_cnt_reg, bad_cnt_next;
    logic [7:0]  good_cnt_reg, good_cnt_next;
    logic [3:0]  slip_cnt_reg, slip_cnt_next;
    logic [15:0] loss_cnt_reg, loss_cnt_next;
    logic        soft_rst_reg, soft_rst_next;
    logic        bitslip_reg, bitslip_next;
    logic        synced_reg;
    logic        stat_vld_reg;
    logic        is_comma, is_bad;

    assign o_DecEnable    = i_Valid & ~i_Rst & (state_reg != ST_SLIP);
    assign o_DecSoftReset = soft_rst_reg;
    assign o_Bitslip      = bitslip_reg;
    assign o_Synced       = synced_reg;
    assign o2_State       = state_reg;
    assign o4_SlipCnt     = slip_cnt_reg;
    assign o16_LossCnt    = loss_cnt_reg;

    assign is_comma = ~i_DErr & i_Kout & (i8_Dout == 8'hBC);
    assign is_bad   = i_DErr | i_DpErr;

    always_comb begin
        state_next      = state_reg;
        word_cnt_next   = word_cnt_reg;
        settle_cnt_next = settle_cnt_reg;
        comma_cnt_next  = comma_cnt_reg;
        bad_cnt_next    = bad_cnt_reg;
        good_cnt_next   = good_cnt_reg;
        slip_cnt_next   = slip_cnt_reg;
        loss_cnt_next   = loss_cnt_reg;
        soft_rst_next   = 1'b0;
        bitslip_next    = 1'b0;
        case (state_reg)
            // Settling ignores decoder status entirely, so in-flight words are dropped here.
            ST_SLIP: begin
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next    = ST_LOS;
                    word_cnt_next = 8'd0;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 4'd1;
                end
            end
            ST_LOS: begin
                if (stat_vld_reg) begin
                    if (is_comma) begin
                        state_next     = ST_CD;
                        comma_cnt_next = 4'd1;
                        word_cnt_next  = 8'd0;
                    end else if (word_cnt_reg == WORD_LAST) begin
                        state_next      = ST_SLIP;
                        bitslip_next    = 1'b1;
                        soft_rst_next   = 1'b1;
                        settle_cnt_next = 4'd0;
                        word_cnt_next   = 8'd0;
                        slip_cnt_next   = (slip_cnt_reg == 4'd9) ? 4'd0 : slip_cnt_reg + 4'd1;
                    end else begin
                        word_cnt_next = word_cnt_reg + 8'd1;
                    end
                end
            end
            ST_CD: begin
                if (stat_vld_reg) begin
                    if (is_bad) begin
                        state_next     = ST_LOS;
                        word_cnt_next  = 8'd0;
                        comma_cnt_next = 4'd0;
                        soft_rst_next  = 1'b1;
                    end else if (is_comma) begin
                        comma_cnt_next = comma_cnt_reg + 4'd1;
                        word_cnt_next  = 8'd0;
                        if ((comma_cnt_reg + 4'd1) >= COMMA_NEED) begin
                            state_next    = ST_SYNC;
                            bad_cnt_next  = 4'd0;
                            good_cnt_next = 8'd0;
                        end
                    end else if (word_cnt_reg == WORD_LAST) begin
                        state_next     = ST_LOS;
                        word_cnt_next  = 8'd0;
                        comma_cnt_next = 4'd0;
                    end else begin
                        word_cnt_next = word_cnt_reg + 8'd1;
                    end
                end
            end
            ST_SYNC: begin
                if (stat_vld_reg) begin
                    if (is_bad) begin
                        if (bad_cnt_reg == BAD_LAST) begin
                            state_next     = ST_LOS;
                            soft_rst_next  = 1'b1;
                            word_cnt_next  = 8'd0;
                            comma_cnt_next = 4'd0;
                            bad_cnt_next   = 4'd0;
                            good_cnt_next  = 8'd0;
                            loss_cnt_next  = (loss_cnt_reg == 16'hFFFF) ? loss_cnt_reg
                                                                         : loss_cnt_reg + 16'd1;
                        end else begin
                            bad_cnt_next  = bad_cnt_reg + 4'd1;
                            good_cnt_next = 8'd0;
                        end
                    end else if (bad_cnt_reg != 4'd0) begin
                        // A full run of good words forgives one earlier bad word.
                        if (good_cnt_reg == GOOD_LAST) begin
                            bad_cnt_next  = bad_cnt_reg - 4'd1;
                            good_cnt_next = 8'd0;
                        end else begin
                            good_cnt_next = good_cnt_reg + 8'd1;
                        end
                    end else begin
                        good_cnt_next = 8'd0;
                    end
                end
            end
            default: state_next = ST_LOS;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_reg      <= ST_LOS;
            word_cnt_reg   <= 8'd0;
            settle_cnt_reg <= 4'd0;
            comma_cnt_reg  <= 4'd0;
            bad_cnt_reg    <= 4'd0;
            good_cnt_reg   <= 8'd0;
            slip_cnt_reg   <= 4'd0;
            loss_cnt_reg   <= 16'd0;
            soft_rst_reg   <= 1'b1;
            bitslip_reg    <= 1'b0;
            synced_reg     <= 1'b0;
            stat_vld_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            word_cnt_reg   <= word_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            comma_cnt_reg  <= comma_cnt_next;
            bad_cnt_reg    <= bad_cnt_next;
            good_cnt_reg   <= good_cnt_next;
            slip_cnt_reg   <= slip_cnt_next;
            loss_cnt_reg   <= loss_cnt_next;
            soft_rst_reg   <= soft_rst_next;
            bitslip_reg    <= bitslip_next;
            synced_reg     <= (state_next == ST_SYNC);
            // Decoder status lags its enable by one cycle and is junk while it is being reset.
            stat_vld_reg   <= o_DecEnable & ~soft_rst_reg;
        end
    end

endmodule

// File: tb/tb_dec8b10b_link_sync.sv
// Directed plus randomized bench for dec8b10b_link_sync, checked every cycle against a word-level model.
module tb_dec8b10b_link_sync;

    localparam int TIMEOUT = 64;
    localparam int SETTLE  = 4;
    localparam int NCOMMA  = 3;
    localparam int MAXBAD  = 4;
    localparam int GOODRUN = 4;

    logic        i_Clk = 1'b0;
    logic        i_Rst = 1'b1;
    logic        i_Valid = 1'b0;
    logic [7:0]  i8_Dout = 8'd0;
    logic        i_Kout = 1'b0;
    logic        i_DErr = 1'b0;
    logic        i_DpErr = 1'b0;
    logic        o_DecEnable, o_DecSoftReset, o_Bitslip, o_Synced;
    logic [1:0]  o2_State;
    logic [3:0]  o4_SlipCnt;
    logic [15:0] o16_LossCnt;

    int vectors = 0;
    int miscompares = 0;

    // Model: 0=LOS 1=SLIP 2=CD 3=SYNC
    int m_state = 0, m_word = 0, m_settle = 0, m_comma = 0, m_bad = 0, m_good = 0;
    int m_slips = 0, m_losses = 0;
    bit m_softrst = 1'b0, m_bitslip = 1'b0, m_statvld = 1'b0;

    dec8b10b_link_sync dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Valid(i_Valid),
        .o_DecEnable(o_DecEnable), .o_DecSoftReset(o_DecSoftReset),
        .i8_Dout(i8_Dout), .i_Kout(i_Kout), .i_DErr(i_DErr), .i_DpErr(i_DpErr),
        .o_Bitslip(o_Bitslip), .o_Synced(o_Synced), .o2_State(o2_State),
        .o4_SlipCnt(o4_SlipCnt), .o16_LossCnt(o16_LossCnt)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit valid, input logic [7:0] d,
                              input bit k, input bit derr, input bit dperr);
        bit comma, bad, nvld;
        comma = !derr && k && (d == 8'hBC);
        bad   = derr || dperr;
        if (rst) begin
            m_state = 0; m_word = 0; m_settle = 0; m_comma = 0; m_bad = 0; m_good = 0;
            m_slips = 0; m_losses = 0; m_softrst = 1; m_bitslip = 0; m_statvld = 0;
            return;
        end
        nvld = valid && (m_state != 1) && !m_softrst;
        m_softrst = 0;
        m_bitslip = 0;
        if (m_state == 1) begin
            if (m_settle == SETTLE - 1) begin m_state = 0; m_word = 0; end
            else m_settle++;
        end else if (m_statvld) begin
            if (m_state == 0) begin
                if (comma) begin m_state = 2; m_comma = 1; m_word = 0; end
                else if (m_word == TIMEOUT - 1) begin
                    m_state = 1; m_bitslip = 1; m_softrst = 1; m_slips++; m_settle = 0; m_word = 0;
                end else m_word++;
            end else if (m_state == 2) begin
                if (bad) begin m_state = 0; m_word = 0; m_comma = 0; m_softrst = 1; end
                else if (comma) begin
                    m_comma++; m_word = 0;
                    if (m_comma >= NCOMMA) begin m_state = 3; m_bad = 0; m_good = 0; end
                end else begin
                    m_word++;
                    if (m_word == TIMEOUT) begin m_state = 0; m_word = 0; m_comma = 0; end
                end
            end else begin
                if (bad) begin
                    if (m_bad == MAXBAD - 1) begin
                        m_state = 0; m_losses++; m_softrst = 1;
                        m_word = 0; m_comma = 0; m_bad = 0; m_good = 0;
                    end else begin m_bad++; m_good = 0; end
                end else if (m_bad > 0) begin
                    m_good++;
                    if (m_good == GOODRUN) begin m_bad--; m_good = 0; end
                end else m_good = 0;
            end
        end
        m_statvld = nvld;
    endtask

    task automatic step(input bit rst, input bit valid, input logic [7:0] d,
                        input bit k, input bit derr, input bit dperr);
        int exp_loss;
        @(negedge i_Clk);
        i_Rst = rst; i_Valid = valid; i8_Dout = d; i_Kout = k; i_DErr = derr; i_DpErr = dperr;
        #1;
        check("dec_enable", 32'(o_DecEnable), 32'(valid && !rst && (m_state != 1)));
        @(posedge i_Clk);
        model_edge(rst, valid, d, k, derr, dperr);
        #1;
        exp_loss = (m_losses > 65535) ? 65535 : m_losses;
        check("soft_reset", 32'(o_DecSoftReset), 32'(m_softrst));
        check("bitslip", 32'(o_Bitslip), 32'(m_bitslip));
        check("synced", 32'(o_Synced), 32'(m_state == 3));
        check("state", 32'(o2_State), 32'(m_state));
        check("slip_cnt", 32'(o4_SlipCnt), 32'(m_slips % 10));
        check("loss_cnt", 32'(o16_LossCnt), 32'(exp_loss));
    endtask

    // kind: 0 good data, 1 K28.5, 2 DErr, 3 DpErr, 4 K28.5 with DpErr
    task automatic word(input int kind, input bit valid, input bit rst);
        logic [7:0] d;
        bit k, de, dp;
        d = 8'($urandom);
        k = 1'($urandom);
        de = 0;
        dp = 0;
        case (kind)
            1: begin d = 8'hBC; k = 1; end
            2: de = 1;
            3: begin dp = 1; if (d == 8'hBC) k = 0; end
            4: begin d = 8'hBC; k = 1; dp = 1; end
            default: if (d == 8'hBC) k = 0;
        endcase
        step(rst, valid, d, k, de, dp);
    endtask

    task automatic feed_commas(input int n);
        for (int i = 0; i < n; i++) word((i % 4 == 0) ? 1 : 0, 1'b1, 1'b0);
    endtask

    task automatic sync_up();
        word(0, 1'b1, 1'b1);
        word(0, 1'b1, 1'b1);
        feed_commas(20);
    endtask

    initial begin
        // 1: reset then aligned stream
        word(0, 1'b1, 1'b1);
        word(0, 1'b0, 1'b1);
        check("t1_rst_softreset", 32'(o_DecSoftReset), 32'd1);
        check("t1_rst_state", 32'(o2_State), 32'd0);
        feed_commas(20);
        check("t1_state_sync", 32'(o2_State), 32'd3);
        check("t1_synced", 32'(o_Synced), 32'd1);
        check("t1_slipcnt", 32'(o4_SlipCnt), 32'd0);

        // 2: slip timeouts and wrap
        word(0, 1'b1, 1'b1);
        for (int c = 0; c < 200 && m_slips < 1; c++) word(0, 1'b1, 1'b0);
        check("t2_first_slip", 32'(o4_SlipCnt), 32'd1);
        check("t2_bitslip_pulse", 32'(o_Bitslip), 32'd1);
        for (int c = 0; c < 1200 && m_slips < 10; c++) word(0, 1'b1, 1'b0);
        check("t2_wrap", 32'(o4_SlipCnt), 32'd0);
        check("t2_state_slip", 32'(o2_State), 32'd1);

        // 3: loss of sync after MAXBAD bad words
        sync_up();
        for (int i = 0; i < 3; i++) word(2, 1'b1, 1'b0);
        check("t3_still_sync", 32'(o2_State), 32'd3);
        word(2, 1'b1, 1'b0);
        check("t3_los", 32'(o2_State), 32'd0);
        check("t3_unsynced", 32'(o_Synced), 32'd0);
        check("t3_losscnt", 32'(o16_LossCnt), 32'd1);
        check("t3_softreset", 32'(o_DecSoftReset), 32'd1);

        // 4: good runs forgive bad words
        sync_up();
        word(2, 1'b1, 1'b0);
        word(2, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) word(0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) word(2, 1'b1, 1'b0);
        check("t4_still_sync", 32'(o2_State), 32'd3);
        word(2, 1'b1, 1'b0);
        check("t4_los", 32'(o2_State), 32'd0);

        // 5: DpErr in CD drops to LOS; K28.5 with DpErr accepted in LOS
        word(0, 1'b1, 1'b1);
        word(0, 1'b1, 1'b1);
        word(0, 1'b1, 1'b0);
        word(0, 1'b1, 1'b0);
        word(1, 1'b1, 1'b0);
        word(0, 1'b1, 1'b0);
        word(1, 1'b1, 1'b0);
        check("t5_cd", 32'(o2_State), 32'd2);
        word(3, 1'b1, 1'b0);
        check("t5_los", 32'(o2_State), 32'd0);
        check("t5_no_bitslip", 32'(o_Bitslip), 32'd0);
        word(4, 1'b1, 1'b0);
        check("t5_cd_again", 32'(o2_State), 32'd2);

        // 6: only valid words count toward timeout; reset mid-SYNC
        word(0, 1'b1, 1'b1);
        for (int c = 0; c < 100; c++) word(0, (c % 2) == 0, 1'b0);
        check("t6_no_slip_yet", 32'(o2_State), 32'd0);
        for (int c = 0; c < 300 && m_slips < 1; c++) word(0, (c % 2) == 0, 1'b0);
        check("t6_slip", 32'(o4_SlipCnt), 32'd1);
        sync_up();
        for (int i = 0; i < 4; i++) word(2, 1'b1, 1'b0);
        feed_commas(20);
        check("t6_resync", 32'(o2_State), 32'd3);
        check("t6_loss_before_rst", 32'(o16_LossCnt), 32'd1);
        word(0, 1'b1, 1'b1);
        check("t6_rst_state", 32'(o2_State), 32'd0);
        check("t6_rst_synced", 32'(o_Synced), 32'd0);
        check("t6_rst_loss", 32'(o16_LossCnt), 32'd0);
        check("t6_rst_softreset", 32'(o_DecSoftReset), 32'd1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r, kind;
            r = int'($urandom_range(99));
            kind = (r < 22) ? 1 : (r < 25) ? 2 : (r < 28) ? 3 : (r < 30) ? 4 : 0;
            word(kind, $urandom_range(3) != 0, $urandom_range(399) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
